bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment scanning display. It converts a 21-bit unsigned binary value (for example, the DDS frequency word) into seven packed BCD digits using an iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. This removes the wide combinational divide/modulo chains from the display path. The display consumes the held `bcd` output and only selects digits, with no arithmetic.

## Interface
- `BIN_W`, default 21: binary input width.
- `DIGITS`, default 7: BCD digit count. Must satisfy 10^DIGITS > 2^BIN_W − 1.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: conversion request. Sampled only in IDLE.
- `bin` input, BIN_W bits: unsigned value. Captured on the accepted `start` edge.
- `busy` output, 1 bit: high while a conversion is in progress.
- `done` output, 1 bit: one-cycle pulse. `bcd` is updated on the same edge.
- `bcd` output, 4*DIGITS bits: packed BCD. `bcd[3:0]` is ones, `bcd[7:4]` is tens, and so on up to `bcd[27:24]` for millions. Held between completions.

## Operation
- FSM with states IDLE and SHIFT.
- IDLE:
  - If `start`=1: capture `bin` into shift register `sr`, clear scratch BCD register `acc`, set `cnt`=0, go to SHIFT.
  - Otherwise: stay in IDLE.
- SHIFT, once per cycle:
  - Adjust step: every 4-bit digit of `acc` that is ≥5 gets +3. This is a combinational adjust over all DIGITS digits.
  - Shift step: shift {adjusted `acc`, `sr`} left by one. The MSB of `sr` enters `acc[0]`.
  - Increment `cnt`.
- Completion, on the SHIFT cycle with `cnt`=BIN_W−1:
  - `bcd` ← the post-shift `acc` value.
  - `done` ← 1.
  - State ← IDLE.
- `start` while in SHIFT is ignored. It is not queued and `bin` is not re-sampled.
- `bin` may change freely after the accepting edge; the conversion uses the captured value.
- Width rules:
  - `cnt` is ceil(log2(BIN_W)) bits.
  - `acc` is 4*DIGITS bits. With legal parameters no digit ever exceeds 9 after a shift, so there is no overflow path.
- Reset (`rst`=1 at any edge, including mid-conversion):
  - State=IDLE, `busy`=0, `done`=0, `bcd`=0, `acc`=0, `sr`=0, `cnt`=0.
  - An in-flight conversion is aborted and produces no `done`.
- Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0.
- Let `start` be accepted at edge N.
  - `busy` is high from after edge N through after edge N+BIN_W−1, i.e. 21 cycles at default parameters.
  - At edge N+BIN_W (N+21): `bcd` updates, `done`=1 for exactly one cycle, `busy`=0.
- Total latency from accepting edge to valid `bcd` is BIN_W edges.
- Back-to-back: `start` high during the `done` cycle is accepted, because the FSM is in IDLE. Throughput is one conversion per BIN_W+1 cycles.
- `bcd` never shows intermediate values; it changes only on a `done` edge or on reset.
- `busy` is registered, derived from the state. `done` is registered.

## Test plan
- Reset then idle: assert `rst` 2 cycles, release, hold `start`=0 for 50 cycles → `bcd`=28'h0000000, `done` and `busy` stay 0.
- Basic values: `bin`=0 → `bcd`=28'h0000000; `bin`=1234567 → `bcd`=28'h1234567. Check `done` arrives exactly 21 edges after the `start` edge and lasts one cycle.
- Full scale: `bin`=2097151 (all ones) → `bcd`=28'h2097151. Also `bin`=9 → 28'h0000009 and `bin`=10 → 28'h0000010 (adjust boundary at digit value 5).
- Ignore during busy: start `bin`=500000, pulse `start` again with `bin`=7 at cycle 10 → single `done`, `bcd`=28'h0500000.
- Reset mid-operation: start `bin`=999999, assert `rst` at cycle 12 → no `done`, `bcd`=0, `busy`=0. A new start with `bin`=42 then yields 28'h0000042.
- Back-to-back plus random: hold `start` high continuously with a new `bin` each accept → `done` every 22 cycles. Run 1000 random values against a decimal reference model, with zero mismatches required.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-and-add-3 (double-dabble) binary-to-BCD
// converter. One input bit is consumed per clock; the packed BCD result is
// held on `bcd` between completions so a display can read it without any
// arithmetic of its own.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int ACC_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   sr;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;

  // Add 3 to every BCD digit that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Adjust the scratch digits, then shift the next binary MSB into the ones digit.
  always_comb begin
    acc_adj   = dabble_adjust(acc);
    acc_shift = {acc_adj[ACC_W-2:0], sr[BIN_W-1]};
  end

  // Control FSM plus datapath registers; busy/done/bcd are all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= {ACC_W{1'b0}};
      acc   <= {ACC_W{1'b0}};
      sr    <= {BIN_W{1'b0}};
      cnt   <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= bin;
            acc   <= {ACC_W{1'b0}};
            cnt   <= {CNT_W{1'b0}};
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here: requests are not queued.
          acc <= acc_shift;
          sr  <= {sr[BIN_W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bcd   <= acc_shift;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed + back-to-back random bench for bin_to_bcd_seq.
// Expected BCD words are computed with a decimal model and queued when a
// conversion is launched; a monitor pops and compares them on each done.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 21;
  localparam int DIGITS = 7;

  logic                clk;
  logic                rst;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int prev_done_cyc = -1;
  bit b2b_mode = 1'b0;
  logic [27:0] exp_q[$];

  // Decimal reference: peel off digits with divide/modulo.
  function automatic logic [27:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    x = v;
    r = 28'h0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle counter used for done-to-done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
      end
      if (b2b_mode && prev_done_cyc >= 0) begin
        chk("b2b_period", 32'(cyc - prev_done_cyc), 32'd22);
      end
      prev_done_cyc = cyc;
    end
  end

  // Launch one conversion, check busy, latency and single-cycle done.
  task automatic convert(input int unsigned v);
    int k;
    bin   = BIN_W'(v);
    start = 1'b1;
    exp_q.push_back(to_bcd(v));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    chk("done_latency", 32'(k), 32'd21);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int base;
    bit act;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    act = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (busy || done) act = 1'b1;
    end
    chk("idle_activity", 32'(act), 32'd0);
    chk("idle_bcd", 32'(bcd), 32'd0);
    chk("idle_done_count", 32'(done_cnt), 32'd0);

    // Basic, full-scale and adjust-boundary values.
    convert(0);
    convert(1234567);
    convert(2097151);
    convert(9);
    convert(10);
    convert(5);

    // start during SHIFT is ignored.
    base  = done_cnt;
    bin   = BIN_W'(500000);
    start = 1'b1;
    exp_q.push_back(to_bcd(500000));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bin   = BIN_W'(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("ignore_single_done", 32'(done_cnt - base), 32'd1);
    chk("ignore_bcd", 32'(bcd), 32'h0500000);

    // Reset in mid-conversion aborts without done.
    base  = done_cnt;
    bin   = BIN_W'(999999);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    convert(42);
    chk("after_abort_bcd", 32'(bcd), 32'h0000042);

    // Back-to-back random stream with start held high.
    b2b_mode      = 1'b1;
    prev_done_cyc = -1;
    base          = done_cnt;
    begin
      int unsigned v;
      v     = $urandom_range(0, 2097151);
      bin   = BIN_W'(v);
      start = 1'b1;
      exp_q.push_back(to_bcd(v));
      @(posedge clk); #1;
      for (int i = 1; i < 1000; i++) begin
        v   = $urandom_range(0, 2097151);
        bin = BIN_W'(v);
        exp_q.push_back(to_bcd(v));
        repeat (22) @(posedge clk);
        #1;
      end
      start = 1'b0;
    end
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("b2b_done_count", 32'(done_cnt - base), 32'd1000);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    b2b_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
